// File: rtl/rst_seq_pkg.sv
// Shared types and default timing constants for the divider reset sequencer.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_HOLD  = 2'd1,
        S_GAP   = 2'd2,
        S_RUN   = 2'd3
    } state_t;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_HOLD_CYCLES = 16;
    localparam int DEF_GAP_CYCLES  = 4;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rst_seq_if.sv
// Soft-reset handshake and divider reset outputs of the reset sequencer.
interface rst_seq_if;
    logic soft_rst_req;
    logic soft_rst_ack;
    logic w_rst;
    logic r_rst;
    logic ready;

    modport master (
        output soft_rst_req,
        input  soft_rst_ack,
        input  w_rst,
        input  r_rst,
        input  ready
    );

    modport slave (
        input  soft_rst_req,
        output soft_rst_ack,
        output w_rst,
        output r_rst,
        output ready
    );
endinterface

// File: rtl/rst_sync.sv
// Reset synchroniser: asserts asynchronously, releases after STAGES clk edges.
module rst_sync
    import rst_seq_pkg::*;
#(
    parameter int STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    output logic rst_n_sync
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], 1'b1};
        end
    end

    assign rst_n_sync = chain[STAGES-1];

endmodule

// File: rtl/rst_seq.sv
// Sequences the write (/2) and read (/3) divider resets after rst_n release and on soft request.
//
// state   | meaning
// S_RESET | waiting for synchronised rst_n release, both resets asserted
// S_HOLD  | both divider resets held
// S_GAP   | w_rst released, r_rst still held
// S_RUN   | both released, ready, soft requests accepted
module rst_seq
    import rst_seq_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int GAP_CYCLES  = DEF_GAP_CYCLES
) (
    input  logic       clk,
    input  logic       rst_n,
    rst_seq_if.slave   bus
);

    localparam int CNT_W        = $clog2(max_int(HOLD_CYCLES, GAP_CYCLES) + 1);
    // The S_RESET exit edge already counts as the first hold cycle after power-on.
    localparam int HOLD_TC_SOFT = HOLD_CYCLES - 1;
    localparam int HOLD_TC_POR  = (HOLD_CYCLES >= 2) ? HOLD_CYCLES - 2 : 0;
    localparam int GAP_TC       = (GAP_CYCLES >= 1) ? GAP_CYCLES - 1 : 0;

    logic             rst_n_sync;
    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             soft_q, soft_nxt;
    logic             req_q;
    logic             req_edge;
    logic             hold_tc;
    logic             gap_tc;
    logic             w_rst_q, w_rst_nxt;
    logic             r_rst_q, r_rst_nxt;
    logic             ready_q, ready_nxt;
    logic             ack_q, ack_nxt;

    rst_sync #(.STAGES(SYNC_STAGES)) u_rst_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .rst_n_sync (rst_n_sync)
    );

    assign req_edge = bus.soft_rst_req & ~req_q;
    assign hold_tc  = (cnt == (soft_q ? CNT_W'(HOLD_TC_SOFT) : CNT_W'(HOLD_TC_POR)));
    assign gap_tc   = (cnt == CNT_W'(GAP_TC));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_RESET;
            cnt     <= '0;
            soft_q  <= 1'b0;
            req_q   <= 1'b1;
            w_rst_q <= 1'b1;
            r_rst_q <= 1'b1;
            ready_q <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            soft_q  <= soft_nxt;
            req_q   <= bus.soft_rst_req;
            w_rst_q <= w_rst_nxt;
            r_rst_q <= r_rst_nxt;
            ready_q <= ready_nxt;
            ack_q   <= ack_nxt;
        end
    end

    // Output flops are loaded with the value of the state being entered.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        soft_nxt  = soft_q;
        w_rst_nxt = w_rst_q;
        r_rst_nxt = r_rst_q;
        ready_nxt = ready_q;
        ack_nxt   = 1'b0;

        case (state)
            S_RESET: begin
                soft_nxt  = 1'b0;
                w_rst_nxt = 1'b1;
                r_rst_nxt = 1'b1;
                ready_nxt = 1'b0;
                if (rst_n_sync) begin
                    cnt_nxt = '0;
                    if (HOLD_CYCLES > 1) begin
                        state_nxt = S_HOLD;
                    end else if (GAP_CYCLES > 0) begin
                        state_nxt = S_GAP;
                        w_rst_nxt = 1'b0;
                    end else begin
                        state_nxt = S_RUN;
                        w_rst_nxt = 1'b0;
                        r_rst_nxt = 1'b0;
                        ready_nxt = 1'b1;
                    end
                end
            end

            S_HOLD: begin
                if (hold_tc) begin
                    cnt_nxt   = '0;
                    w_rst_nxt = 1'b0;
                    if (GAP_CYCLES > 0) begin
                        state_nxt = S_GAP;
                    end else begin
                        state_nxt = S_RUN;
                        r_rst_nxt = 1'b0;
                        ready_nxt = 1'b1;
                        ack_nxt   = soft_q;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            S_GAP: begin
                if (gap_tc) begin
                    state_nxt = S_RUN;
                    cnt_nxt   = '0;
                    r_rst_nxt = 1'b0;
                    ready_nxt = 1'b1;
                    ack_nxt   = soft_q;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            S_RUN: begin
                if (req_edge) begin
                    state_nxt = S_HOLD;
                    cnt_nxt   = '0;
                    soft_nxt  = 1'b1;
                    w_rst_nxt = 1'b1;
                    r_rst_nxt = 1'b1;
                    ready_nxt = 1'b0;
                end
            end

            default: begin
                state_nxt = S_RESET;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign bus.w_rst        = w_rst_q;
    assign bus.r_rst        = r_rst_q;
    assign bus.ready        = ready_q;
    assign bus.soft_rst_ack = ack_q;

endmodule

// File: doc/rst_seq.md
RST_SEQ -- requirements
Module: rst_seq

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2: number of reset-deassertion synchroniser flops; legal values are 2 or more.
REQ-002 The block SHALL have parameter HOLD_CYCLES, default 16: number of clk cycles both divider resets are held after release; legal values are 1 or more.
REQ-003 The block SHALL have parameter GAP_CYCLES, default 4: number of clk cycles between w_rst release and r_rst release; legal values are 0 or more.
REQ-004 The block SHALL have port clk, input, 1 bit: 100 MHz source clock, also the divider input clock; the block uses a single clock.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port soft_rst_req, input, 1 bit: level input; its rising edge requests a divider reset sequence.
REQ-007 The block SHALL have port soft_rst_ack, output, 1 bit: one-cycle pulse marking completion of a soft sequence.
REQ-008 The block SHALL have port w_rst, output, 1 bit: active-high reset to the write-clock divider (÷2).
REQ-009 The block SHALL have port r_rst, output, 1 bit: active-high reset to the read-clock divider (÷3).
REQ-010 The block SHALL have port ready, output, 1 bit: high when both divider resets are released and the block is idle.

Function
REQ-011 States SHALL be: S_RESET, then S_HOLD (both resets asserted), then S_GAP (w_rst released, r_rst asserted), then S_RUN (both released, ready=1).
REQ-012 rst_n deassertion SHALL pass through the SYNC_STAGES-flop synchroniser; S_RESET SHALL exit to S_HOLD when the synchroniser output is high.
REQ-013 After rst_n rises, w_rst SHALL fall at rising edge number SYNC_STAGES+HOLD_CYCLES (edge 1 is the first edge after the rise).
REQ-014 r_rst and ready SHALL change together at edge SYNC_STAGES+HOLD_CYCLES+GAP_CYCLES; when GAP_CYCLES=0, S_GAP is skipped and w_rst, r_rst and ready all change on the same edge.
REQ-015 w_rst, r_rst, ready and soft_rst_ack SHALL be driven directly by flops, with no combinational decode, so the clocked dividers see no glitches.
REQ-016 soft_rst_req SHALL be edge-detected with a one-flop history; an edge is a sample of 1 when the previous sample was 0.
REQ-017 A soft_rst_req edge sampled at edge E while in S_RUN SHALL, at edge E, assert w_rst and r_rst, deassert ready, and enter S_HOLD.
REQ-018 During a soft sequence, w_rst SHALL fall at E+HOLD_CYCLES; r_rst and ready SHALL rise/fall at E+HOLD_CYCLES+GAP_CYCLES, where soft_rst_ack SHALL be 1 for exactly that one cycle.
REQ-019 soft_rst_req edges outside S_RUN SHALL be dropped, neither queued nor acknowledged.
REQ-020 soft_rst_req held high continuously SHALL trigger at most one sequence.
REQ-021 soft_rst_ack SHALL never pulse for a power-on or rst_n sequence.
REQ-022 The phase cycle counter SHALL be sized as clog2(max(HOLD_CYCLES,GAP_CYCLES)+1) bits, SHALL be cleared on every state entry, and SHALL never wrap.
REQ-023 w_rst SHALL never be low while r_rst is high only because of a later request: the release order is always w_rst first, then r_rst.

Reset
REQ-024 rst_n low SHALL asynchronously force w_rst=1, r_rst=1, ready=0, soft_rst_ack=0, state=S_RESET, counter=0 and synchroniser=0, in any state including mid-sequence.
REQ-025 The soft_rst_req history flop SHALL reset to 1, so a request held high across reset does not trigger.
REQ-026 rst_n asserted during soft_rst_ack SHALL clear the pulse immediately.

Structure
REQ-027 Package rst_seq_pkg SHALL hold the state enum and the default HOLD/GAP/SYNC constants.
REQ-028 Sub-module rst_sync SHALL implement the parameterised asynchronous-assert, synchronous-deassert flop chain.
REQ-029 The synchroniser SHALL be the only logic clocked by clk on the rst_n path; the sequencer itself has no other sub-modules.

Verification
REQ-030 Defaults, rst_n released -> w_rst falls at edge 18; r_rst and ready change at edge 22; soft_rst_ack stays 0 throughout.
REQ-031 GAP_CYCLES=0, rst_n released -> w_rst, r_rst and ready all change at edge 18.
REQ-032 In S_RUN, soft_rst_req pulsed at edge E -> resets asserted at E; w_rst falls at E+16; r_rst falls and ack is high for one cycle at E+20.
REQ-033 soft_rst_req held high for 40 cycles -> exactly one sequence and one ack; a second edge during S_HOLD is ignored.
REQ-034 rst_n pulsed low at edge E+10 of a soft sequence -> all outputs reset asynchronously and no ack is produced; the power-on timing of REQ-030 then repeats.
REQ-035 soft_rst_req high across rst_n release -> no soft sequence is started.
